// File: rtl/fpadd_result_queue_pkg.sv
// fpadd_pkg: shared double-precision field widths and result class decoding
package fpadd_pkg;
  localparam int FP_W = 64;
  localparam int EXP_W = 11;
  localparam int FRAC_W = 52;
  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF = 3'd3;
  localparam logic [2:0] CLS_NAN = 3'd4;
  function automatic logic [2:0] fp_class(input logic [FP_W-1:0] d);
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    e = d[FP_W-2 -: EXP_W];
    f = d[FRAC_W-1:0];
    return (e == '0) ? ((f == '0) ? CLS_ZERO : CLS_SUB) :
           (&e) ? ((f == '0) ? CLS_INF : CLS_NAN) : CLS_NORM;
  endfunction
endpackage

// File: rtl/fpadd_result_queue_if.sv
// fpadd_result_queue_if: adder-side push, consumer-side pop and status of the result queue
// FPADD_RESULT_QUEUE_CLASS_EN adds class_out and clr_err
interface fpadd_result_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;
  logic pushin, stopout, pushout, stopin, overflow;
  logic [63:0] r_in, r_out;
  logic [CW-1:0] count;
`ifdef FPADD_RESULT_QUEUE_CLASS_EN
  logic [2:0] class_out;
  logic clr_err;
  modport master(output pushin, r_in, stopin, clr_err,
                 input stopout, pushout, r_out, count, overflow, class_out);
  modport slave(input pushin, r_in, stopin, clr_err,
                output stopout, pushout, r_out, count, overflow, class_out);
`else
  modport master(output pushin, r_in, stopin,
                 input stopout, pushout, r_out, count, overflow);
  modport slave(input pushin, r_in, stopin,
                output stopout, pushout, r_out, count, overflow);
`endif
endinterface

// File: rtl/fpadd_result_queue_class.sv
// fp_class_decode: combinational class decode of a double at push time
module fp_class_decode
  import fpadd_pkg::*;
(
  input  logic [FP_W-1:0] d,
  output logic [2:0]      cls
);
  assign cls = fp_class(d);
endmodule

// File: rtl/fpadd_result_queue.sv
// fpadd_result_queue: FWFT circular queue behind the double adder with skid-aware stopout
// FPADD_RESULT_QUEUE_CLASS_EN stores a per-entry class code and adds clr_err
module fpadd_result_queue
  import fpadd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID = 2
) (
  input logic clk,
  input logic rst_n,
  fpadd_result_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = CW - 1;
`ifdef FPADD_RESULT_QUEUE_CLASS_EN
  localparam int SW = FP_W + 3;
`else
  localparam int SW = FP_W;
`endif
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wdata, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nx;
  logic full, pop, wr, drop, stop, ov;
`ifdef FPADD_RESULT_QUEUE_CLASS_EN
  logic [2:0] cls;
  fp_class_decode u_cls (.d(q.r_in), .cls(cls));
  assign wdata = {cls, q.r_in};
  assign q.class_out = head[SW-1:FP_W];
`else
  assign wdata = q.r_in;
`endif
  always_comb begin
    full = cnt == CW'(DEPTH);
    pop = (cnt != '0) && !q.stopin;
    wr = q.pushin && (!full || pop);
    drop = q.pushin && full && !pop;
    cnt_nx = cnt + CW'(wr) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      stop <= 1'b0;
      ov <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt <= cnt_nx;
      stop <= cnt_nx >= CW'(DEPTH - SKID);
`ifdef FPADD_RESULT_QUEUE_CLASS_EN
      ov <= drop ? 1'b1 : q.clr_err ? 1'b0 : ov;
`else
      ov <= ov | drop;
`endif
    end
  assign head = mem[rd_ptr];
  assign q.r_out = head[FP_W-1:0];
  assign q.pushout = cnt != '0;
  assign q.count = cnt;
  assign q.stopout = stop;
  assign q.overflow = ov;
endmodule
